input_handshake: RTL and testbench

INPUT_HANDSHAKE -- requirements
Module: input_handshake

---
 rtl/input_handshake.sv | 112 +++++++++++
 tb/tb_input_handshake.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_handshake.sv
// rtl/input_handshake.sv - debounced push-button handshake that captures the switch word on request
// Key path: 2-flop synchronizer, counter debouncer, edge pulses, four-state capture FSM.
module input_handshake #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [17:0] switches,
   input  logic        key_n,
   input  logic        read_request,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        stall,
   output logic        waiting_led
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      ARMED        = 2'd1,
      CAPTURED     = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        key_stable_q, key_stable_d;
   logic        key_prev_q, key_prev_d;
   logic [19:0] cnt_q, cnt_d;
   state_t      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic        press;
   logic        release_pulse;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         key_stable_q <= 1'b1;
         key_prev_q   <= 1'b1;
         cnt_q        <= '0;
         state_q      <= IDLE;
         data_q       <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         key_stable_q <= key_stable_d;
         key_prev_q   <= key_prev_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         data_q       <= data_d;
      end
   end

   // The counter only runs while the synchronized key disagrees with the accepted level.
   always_comb begin
      sync1_d      = key_n;
      sync2_d      = sync1_q;
      key_stable_d = key_stable_q;
      key_prev_d   = key_stable_q;
      cnt_d        = '0;
      if (sync2_q != key_stable_q) begin
         if (cnt_q == CNT_MAX) begin
            key_stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
   end

   assign press         = key_prev_q & ~key_stable_q;
   assign release_pulse = ~key_prev_q & key_stable_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (read_request) begin
               state_d = key_stable_q ? ARMED : RELEASE_WAIT;
            end
         end
         ARMED: begin
            // A press in the same cycle as a request drop still captures.
            if (press) begin
               data_d  = {14'b0, switches};
               state_d = CAPTURED;
            end else if (!read_request) begin
               state_d = IDLE;
            end
         end
         CAPTURED: begin
            state_d = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (release_pulse || key_stable_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_out    = data_q;
   assign data_valid  = (state_q == CAPTURED);
   assign waiting_led = (state_q == ARMED);
   assign stall       = read_request & (state_q != CAPTURED);

endmodule

// File: tb/tb_input_handshake.sv
// tb/tb_input_handshake.sv - directed self-checking bench for input_handshake
// Inputs change and outputs are sampled on the falling clock edge.
module tb_input_handshake;

   logic        clock;
   logic        reset;
   logic [17:0] switches;
   logic        key_n;
   logic        read_request;
   logic [31:0] data_out;
   logic        data_valid;
   logic        stall;
   logic        waiting_led;

   int n_tests;
   int n_fail;

   input_handshake #(.DEBOUNCE_CYCLES(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .switches     (switches),
      .key_n        (key_n),
      .read_request (read_request),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .stall        (stall),
      .waiting_led  (waiting_led)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic observe(input int n, output int pulses, output int first_at);
      pulses   = 0;
      first_at = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clock);
         if (data_valid === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
   endtask

   task automatic test_reset;
      read_request = 1'b1;
      key_n        = 1'b1;
      switches     = 18'h3FFFF;
      reset        = 1'b1;
      tick(2);
      n_tests++;
      if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
      n_tests++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
      n_tests++;
      if (waiting_led !== 1'b0) begin n_fail++; $display("FAIL reset_waiting_led: got %b expected 0", waiting_led); end
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req1: got %b expected 1", stall); end
      read_request = 1'b0;
      tick(1);
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req0: got %b expected 0", stall); end
      reset = 1'b0;
      tick(2);
      n_tests++;
      if (waiting_led !== 1'b0) begin n_fail++; $display("FAIL idle_waiting_led: got %b expected 0", waiting_led); end
   endtask

   task automatic test_clean_press;
      int   first_at;
      int   pulses;
      logic pre_ok;
      logic dv_stall;
      logic [31:0] dv_data;
      switches     = 18'h2A5F3;
      read_request = 1'b1;
      tick(1);
      n_tests++;
      if (waiting_led !== 1'b1 || stall !== 1'b1) begin
         n_fail++; $display("FAIL armed_outputs: got led=%b stall=%b expected led=1 stall=1", waiting_led, stall);
      end
      key_n    = 1'b0;
      first_at = -1;
      pulses   = 0;
      pre_ok   = 1'b1;
      dv_stall = 1'bx;
      dv_data  = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (data_valid === 1'b1) begin
            pulses++;
            if (first_at < 0) begin
               first_at = i;
               dv_stall = stall;
               dv_data  = data_out;
            end
         end else if (first_at < 0 && (stall !== 1'b1 || waiting_led !== 1'b1)) begin
            pre_ok = 1'b0;
         end
      end
      n_tests++;
      if (pre_ok !== 1'b1) begin n_fail++; $display("FAIL clean_wait_outputs: got pre_ok=%b expected 1", pre_ok); end
      n_tests++;
      if (first_at != 7) begin n_fail++; $display("FAIL clean_latency: got %0d expected 7", first_at); end
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL clean_pulses: got %0d expected 1", pulses); end
      n_tests++;
      if (dv_data !== 32'h0002A5F3) begin n_fail++; $display("FAIL clean_data: got %h expected %h", dv_data, 32'h0002A5F3); end
      n_tests++;
      if (dv_stall !== 1'b0) begin n_fail++; $display("FAIL clean_stall_in_valid: got %b expected 0", dv_stall); end
      n_tests++;
      if (stall !== 1'b1 || waiting_led !== 1'b0) begin
         n_fail++; $display("FAIL release_wait_outputs: got stall=%b led=%b expected stall=1 led=0", stall, waiting_led);
      end
      key_n        = 1'b1;
      read_request = 1'b0;
      tick(12);
   endtask

   task automatic test_bounce;
      int pulses_during;
      int pulses;
      int first_at;
      int p;
      int f;
      read_request  = 1'b1;
      tick(1);
      pulses_during = 0;
      for (int i = 0; i < 10; i++) begin
         key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         observe(2, p, f);
         pulses_during += p;
      end
      key_n = 1'b0;
      observe(20, pulses, first_at);
      n_tests++;
      if (pulses_during != 0) begin n_fail++; $display("FAIL bounce_no_early: got %0d expected 0", pulses_during); end
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
      n_tests++;
      if (first_at != 7) begin n_fail++; $display("FAIL bounce_latency: got %0d expected 7", first_at); end
      key_n        = 1'b1;
      read_request = 1'b0;
      tick(12);
   endtask

   task automatic test_held_before_request;
      int pulses;
      int first_at;
      switches     = 18'h12345;
      read_request = 1'b0;
      key_n        = 1'b0;
      tick(10);
      read_request = 1'b1;
      tick(1);
      n_tests++;
      if (waiting_led !== 1'b0 || stall !== 1'b1) begin
         n_fail++; $display("FAIL held_release_wait: got led=%b stall=%b expected led=0 stall=1", waiting_led, stall);
      end
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 0) begin n_fail++; $display("FAIL held_no_capture: got %0d expected 0", pulses); end
      key_n = 1'b1;
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 0 || waiting_led !== 1'b1) begin
         n_fail++; $display("FAIL held_rearm: got pulses=%0d led=%b expected pulses=0 led=1", pulses, waiting_led);
      end
      key_n = 1'b0;
      observe(12, pulses, first_at);
      n_tests++;
      if (pulses != 1 || first_at != 7) begin
         n_fail++; $display("FAIL held_second_press: got pulses=%0d at=%0d expected pulses=1 at=7", pulses, first_at);
      end
      n_tests++;
      if (data_out !== 32'h00012345) begin n_fail++; $display("FAIL held_data: got %h expected %h", data_out, 32'h00012345); end
      key_n        = 1'b1;
      read_request = 1'b0;
      tick(12);
   endtask

   task automatic test_back_to_back;
      int pulses;
      int first_at;
      read_request = 1'b1;
      switches     = 18'h00001;
      tick(1);
      key_n = 1'b0;
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 1 || data_out !== 32'h00000001) begin
         n_fail++; $display("FAIL b2b_first: got pulses=%0d data=%h expected pulses=1 data=%h", pulses, data_out, 32'h1);
      end
      key_n    = 1'b1;
      switches = 18'h3FFFF;
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 0 || data_out !== 32'h00000001 || waiting_led !== 1'b1) begin
         n_fail++; $display("FAIL b2b_hold: got pulses=%0d data=%h led=%b expected 0 %h 1", pulses, data_out, waiting_led, 32'h1);
      end
      key_n = 1'b0;
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 1 || data_out !== 32'h0003FFFF) begin
         n_fail++; $display("FAIL b2b_second: got pulses=%0d data=%h expected pulses=1 data=%h", pulses, data_out, 32'h0003FFFF);
      end
      key_n        = 1'b1;
      read_request = 1'b0;
      tick(12);
   endtask

   task automatic test_abort_and_coincide;
      int pulses;
      int first_at;
      read_request = 1'b1;
      tick(1);
      read_request = 1'b0;
      tick(1);
      n_tests++;
      if (waiting_led !== 1'b0 || data_out !== 32'h0003FFFF) begin
         n_fail++; $display("FAIL drop_abort: got led=%b data=%h expected led=0 data=%h", waiting_led, data_out, 32'h0003FFFF);
      end
      observe(4, pulses, first_at);
      n_tests++;
      if (pulses != 0) begin n_fail++; $display("FAIL drop_no_capture: got %0d expected 0", pulses); end
      switches     = 18'h15555;
      read_request = 1'b1;
      tick(1);
      key_n = 1'b0;
      tick(6);
      read_request = 1'b0;
      tick(1);
      n_tests++;
      if (data_valid !== 1'b1 || stall !== 1'b0 || data_out !== 32'h00015555) begin
         n_fail++; $display("FAIL coincide_capture: got dv=%b stall=%b data=%h expected dv=1 stall=0 data=%h", data_valid, stall, data_out, 32'h00015555);
      end
      tick(1);
      n_tests++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL coincide_single: got %b expected 0", data_valid); end
      key_n = 1'b1;
      tick(12);
   endtask

   task automatic test_reset_abort;
      int pulses;
      int first_at;
      switches     = 18'h0ABCD;
      read_request = 1'b1;
      tick(1);
      key_n = 1'b0;
      tick(2);
      reset        = 1'b1;
      read_request = 1'b0;
      tick(3);
      n_tests++;
      if (data_valid !== 1'b0 || data_out !== 32'h0 || waiting_led !== 1'b0) begin
         n_fail++; $display("FAIL rst_abort: got dv=%b data=%h led=%b expected 0 0 0", data_valid, data_out, waiting_led);
      end
      reset = 1'b0;
      observe(12, pulses, first_at);
      read_request = 1'b1;
      tick(1);
      n_tests++;
      if (pulses != 0 || waiting_led !== 1'b0) begin
         n_fail++; $display("FAIL rst_held_key: got pulses=%0d led=%b expected 0 0", pulses, waiting_led);
      end
      observe(10, pulses, first_at);
      n_tests++;
      if (pulses != 0 || data_out !== 32'h0) begin
         n_fail++; $display("FAIL rst_no_capture: got pulses=%0d data=%h expected 0 0", pulses, data_out);
      end
      key_n = 1'b1;
      observe(10, pulses, first_at);
      key_n = 1'b0;
      observe(12, pulses, first_at);
      n_tests++;
      if (pulses != 1 || data_out !== 32'h0000ABCD) begin
         n_fail++; $display("FAIL rst_new_press: got pulses=%0d data=%h expected 1 %h", pulses, data_out, 32'h0000ABCD);
      end
      key_n        = 1'b1;
      read_request = 1'b0;
      tick(12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset        = 1'b1;
      key_n        = 1'b1;
      read_request = 1'b0;
      switches     = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_held_before_request();
      test_back_to_back();
      test_abort_and_coincide();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
